// File: rtl/jsp_cpu_pkg.sv
// Shared constants for the CPU datapath: exchange sequencer state encodings,
// the default register width and a helper for sizing the pair select.
package jsp_cpu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] XCHG_IDLE    = 2'd0;
    localparam logic [1:0] XCHG_SAVE    = 2'd1;
    localparam logic [1:0] XCHG_MOVE    = 2'd2;
    localparam logic [1:0] XCHG_RESTORE = 2'd3;

    // A bank of two registers has a single pair but still needs a 1-bit select.
    function automatic int pair_sel_width(input int num_regs);
        if (num_regs / 2 > 1) begin
            return $clog2(num_regs / 2);
        end
        return 1;
    endfunction

endpackage

// File: rtl/reg_pair_incdec.sv
// Combinational +1/-1 on a register pair treated as one 2*WIDTH-bit value.
// Both or neither request leaves the value unchanged.
module reg_pair_incdec
    import jsp_cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] pair_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [2*WIDTH-1:0] pair_o
);

    // Natural modulo-2^(2*WIDTH) wrap carries/borrows across the two halves.
    always_comb begin
        pair_o = pair_i;
        if (inc_i && !dec_i) begin
            pair_o = pair_i + 1'b1;
        end else if (dec_i && !inc_i) begin
            pair_o = pair_i - 1'b1;
        end
    end

endmodule

// File: rtl/register_file_gp.sv
// General-purpose register bank: three gated read ports, one bus write port,
// register-pair increment/decrement and a three-step register exchange sequencer.
module register_file_gp
    import jsp_cpu_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               NUM_REGS    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              SEL_W       = $clog2(NUM_REGS),
    localparam int              PAIR_W      = pair_sel_width(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    bus_in,
    input  logic                load_bus,
    input  logic [SEL_W-1:0]    load_sel,
    input  logic [SEL_W-1:0]    lhs_sel,
    input  logic [SEL_W-1:0]    rhs_sel,
    input  logic [SEL_W-1:0]    bus_sel,
    input  logic                assert_lhs,
    input  logic                assert_rhs,
    input  logic                assert_bus,
    output logic [WIDTH-1:0]    lhs_out,
    output logic [WIDTH-1:0]    rhs_out,
    output logic [WIDTH-1:0]    bus_out,
    output logic                lhs_en,
    output logic                rhs_en,
    output logic                bus_en,
    input  logic [PAIR_W-1:0]   pair_sel,
    input  logic                pair_inc,
    input  logic                pair_dec,
    output logic [2*WIDTH-1:0]  pair_out,
    input  logic                xchg_start,
    input  logic [SEL_W-1:0]    xchg_a,
    input  logic [SEL_W-1:0]    xchg_b,
    output logic                busy,
    output logic [1:0]          xchg_state
);

    logic [WIDTH-1:0]   regs_q [NUM_REGS];
    logic [WIDTH-1:0]   regs_d [NUM_REGS];
    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   tmp_q, tmp_d;
    logic [SEL_W-1:0]   a_q, a_d;
    logic [SEL_W-1:0]   b_q, b_d;

    logic               pair_valid;
    logic [SEL_W-1:0]   pair_lo_idx;
    logic [SEL_W-1:0]   pair_hi_idx;
    logic [2*WIDTH-1:0] pair_cur;
    logic [2*WIDTH-1:0] pair_next;
    logic               pair_op;
    logic               pair_hit;
    logic               load_ok;
    logic               xchg_ok;

    // Read ports: combinational, no write bypass; enables are pure pass-through.
    assign lhs_en  = assert_lhs;
    assign rhs_en  = assert_rhs;
    assign bus_en  = assert_bus;
    assign lhs_out = (assert_lhs && int'(lhs_sel) < NUM_REGS) ? regs_q[lhs_sel] : '0;
    assign rhs_out = (assert_rhs && int'(rhs_sel) < NUM_REGS) ? regs_q[rhs_sel] : '0;
    assign bus_out = (assert_bus && int'(bus_sel) < NUM_REGS) ? regs_q[bus_sel] : '0;

    assign pair_valid  = int'(pair_sel) < NUM_REGS / 2;
    assign pair_lo_idx = SEL_W'({pair_sel, 1'b0});
    assign pair_hi_idx = SEL_W'({pair_sel, 1'b1});
    assign pair_cur    = pair_valid ? {regs_q[pair_hi_idx], regs_q[pair_lo_idx]} : '0;
    assign pair_out    = pair_cur;

    assign pair_op  = (pair_inc ^ pair_dec) && pair_valid;
    assign load_ok  = int'(load_sel) < NUM_REGS;
    // A load into either half of the selected pair wins and drops the whole pair op.
    assign pair_hit = load_bus && (load_sel == pair_lo_idx || load_sel == pair_hi_idx);
    assign xchg_ok  = int'(xchg_a) < NUM_REGS && int'(xchg_b) < NUM_REGS;

    reg_pair_incdec #(
        .WIDTH (WIDTH)
    ) u_pair_incdec (
        .pair_i (pair_cur),
        .inc_i  (pair_inc),
        .dec_i  (pair_dec),
        .pair_o (pair_next)
    );

    always_comb begin
        regs_d  = regs_q;
        state_d = state_q;
        tmp_d   = tmp_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            XCHG_IDLE: begin
                if (xchg_start && xchg_ok) begin
                    a_d     = xchg_a;
                    b_d     = xchg_b;
                    state_d = XCHG_SAVE;
                end else begin
                    if (pair_op && !pair_hit) begin
                        regs_d[pair_lo_idx] = pair_next[WIDTH-1:0];
                        regs_d[pair_hi_idx] = pair_next[2*WIDTH-1:WIDTH];
                    end
                    if (load_bus && load_ok) begin
                        regs_d[load_sel] = bus_in;
                    end
                end
            end
            XCHG_SAVE: begin
                tmp_d   = regs_q[a_q];
                state_d = XCHG_MOVE;
            end
            XCHG_MOVE: begin
                regs_d[a_q] = regs_q[b_q];
                state_d     = XCHG_RESTORE;
            end
            default: begin
                regs_d[b_q] = tmp_q;
                state_d     = XCHG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
            state_q <= XCHG_IDLE;
            tmp_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            tmp_q   <= tmp_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign busy       = (state_q != XCHG_IDLE);
    assign xchg_state = state_q;

endmodule

// File: tb/tb_register_file_gp.sv
// Directed bench for register_file_gp: default 8x4 bank plus 4x2 and 16x8 variants.
module tb_register_file_gp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Default instance: WIDTH=8, NUM_REGS=4
    logic [7:0]  bus_in;
    logic        load_bus;
    logic [1:0]  load_sel, lhs_sel, rhs_sel, bus_sel;
    logic        assert_lhs, assert_rhs, assert_bus;
    logic [7:0]  lhs_out, rhs_out, bus_out;
    logic        lhs_en, rhs_en, bus_en;
    logic [0:0]  pair_sel;
    logic        pair_inc, pair_dec;
    logic [15:0] pair_out;
    logic        xchg_start;
    logic [1:0]  xchg_a, xchg_b;
    logic        busy;
    logic [1:0]  xchg_state;

    register_file_gp dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .load_bus(load_bus), .load_sel(load_sel),
        .lhs_sel(lhs_sel), .rhs_sel(rhs_sel), .bus_sel(bus_sel),
        .assert_lhs(assert_lhs), .assert_rhs(assert_rhs), .assert_bus(assert_bus),
        .lhs_out(lhs_out), .rhs_out(rhs_out), .bus_out(bus_out),
        .lhs_en(lhs_en), .rhs_en(rhs_en), .bus_en(bus_en),
        .pair_sel(pair_sel), .pair_inc(pair_inc), .pair_dec(pair_dec), .pair_out(pair_out),
        .xchg_start(xchg_start), .xchg_a(xchg_a), .xchg_b(xchg_b), .busy(busy),
        .xchg_state(xchg_state)
    );

    // Small instance: WIDTH=4, NUM_REGS=2
    logic [3:0] s_bus_in;
    logic       s_load_bus;
    logic [0:0] s_load_sel, s_bus_sel, s_xchg_a, s_xchg_b;
    logic [0:0] s_rd_sel = 1'b0;
    logic       s_assert_bus;
    logic [3:0] s_lhs_out, s_rhs_out, s_bus_out;
    logic       s_lhs_en, s_rhs_en, s_bus_en;
    logic [0:0] s_pair_sel = 1'b0;
    logic       s_pair_inc;
    logic [7:0] s_pair_out;
    logic       s_xchg_start, s_busy;
    logic [1:0] s_xchg_state;

    register_file_gp #(.WIDTH(4), .NUM_REGS(2)) dut_s (
        .clk(clk), .reset(reset), .bus_in(s_bus_in), .load_bus(s_load_bus), .load_sel(s_load_sel),
        .lhs_sel(s_rd_sel), .rhs_sel(s_rd_sel), .bus_sel(s_bus_sel),
        .assert_lhs(1'b0), .assert_rhs(1'b0), .assert_bus(s_assert_bus),
        .lhs_out(s_lhs_out), .rhs_out(s_rhs_out), .bus_out(s_bus_out),
        .lhs_en(s_lhs_en), .rhs_en(s_rhs_en), .bus_en(s_bus_en),
        .pair_sel(s_pair_sel), .pair_inc(s_pair_inc), .pair_dec(1'b0), .pair_out(s_pair_out),
        .xchg_start(s_xchg_start), .xchg_a(s_xchg_a), .xchg_b(s_xchg_b), .busy(s_busy),
        .xchg_state(s_xchg_state)
    );

    // Wide instance: WIDTH=16, NUM_REGS=8
    logic [15:0] w_bus_in;
    logic        w_load_bus;
    logic [2:0]  w_load_sel, w_bus_sel, w_xchg_a, w_xchg_b;
    logic [2:0]  w_rd_sel = 3'd0;
    logic        w_assert_bus;
    logic [15:0] w_lhs_out, w_rhs_out, w_bus_out;
    logic        w_lhs_en, w_rhs_en, w_bus_en;
    logic [1:0]  w_pair_sel;
    logic        w_pair_inc, w_pair_dec;
    logic [31:0] w_pair_out;
    logic        w_xchg_start, w_busy;
    logic [1:0]  w_xchg_state;

    register_file_gp #(.WIDTH(16), .NUM_REGS(8)) dut_w (
        .clk(clk), .reset(reset), .bus_in(w_bus_in), .load_bus(w_load_bus), .load_sel(w_load_sel),
        .lhs_sel(w_rd_sel), .rhs_sel(w_rd_sel), .bus_sel(w_bus_sel),
        .assert_lhs(1'b0), .assert_rhs(1'b0), .assert_bus(w_assert_bus),
        .lhs_out(w_lhs_out), .rhs_out(w_rhs_out), .bus_out(w_bus_out),
        .lhs_en(w_lhs_en), .rhs_en(w_rhs_en), .bus_en(w_bus_en),
        .pair_sel(w_pair_sel), .pair_inc(w_pair_inc), .pair_dec(w_pair_dec), .pair_out(w_pair_out),
        .xchg_start(w_xchg_start), .xchg_a(w_xchg_a), .xchg_b(w_xchg_b), .busy(w_busy),
        .xchg_state(w_xchg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [1:0] sel, input logic [7:0] val);
        load_bus = 1'b1;
        load_sel = sel;
        bus_in   = val;
        tick();
        load_bus = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        rhs_sel    = idx;
        assert_rhs = 1'b1;
        #1;
        check_eq(tag, rhs_out, exp);
        assert_rhs = 1'b0;
        #1;
    endtask

    task automatic s_load(input logic [0:0] sel, input logic [3:0] val);
        s_load_bus = 1'b1;
        s_load_sel = sel;
        s_bus_in   = val;
        tick();
        s_load_bus = 1'b0;
    endtask

    task automatic w_load(input logic [2:0] sel, input logic [15:0] val);
        w_load_bus = 1'b1;
        w_load_sel = sel;
        w_bus_in   = val;
        tick();
        w_load_bus = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_in = '0; load_bus = 0; load_sel = '0; lhs_sel = '0; rhs_sel = '0; bus_sel = '0;
        assert_lhs = 0; assert_rhs = 0; assert_bus = 0; pair_sel = '0; pair_inc = 0; pair_dec = 0;
        xchg_start = 0; xchg_a = '0; xchg_b = '0;
        s_bus_in = '0; s_load_bus = 0; s_load_sel = '0; s_bus_sel = '0; s_assert_bus = 0;
        s_pair_inc = 0; s_xchg_start = 0; s_xchg_a = '0; s_xchg_b = '0;
        w_bus_in = '0; w_load_bus = 0; w_load_sel = '0; w_bus_sel = '0; w_assert_bus = 0;
        w_pair_sel = '0; w_pair_inc = 0; w_pair_dec = 0; w_xchg_start = 0; w_xchg_a = '0; w_xchg_b = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_busy", busy, 0);
        check_eq("rst_state", xchg_state, 0);
        check_eq("rst_pair", pair_out, 16'h0000);
        chk_reg("rst_r3", 2'd3, 8'h00);

        // Loads and three read ports
        load_reg(2'd0, 8'h11);
        load_reg(2'd1, 8'h22);
        load_reg(2'd2, 8'h33);
        load_reg(2'd3, 8'h44);
        lhs_sel = 2'd1; rhs_sel = 2'd2; bus_sel = 2'd3;
        assert_lhs = 1; assert_rhs = 1; assert_bus = 1;
        #1;
        check_eq("rd_lhs", lhs_out, 8'h22);
        check_eq("rd_rhs", rhs_out, 8'h33);
        check_eq("rd_bus", bus_out, 8'h44);
        check_eq("rd_en", {lhs_en, rhs_en, bus_en}, 3'b111);
        assert_lhs = 0; assert_rhs = 0; assert_bus = 0;
        #1;
        check_eq("off_lhs", lhs_out, 8'h00);
        check_eq("off_rhs", rhs_out, 8'h00);
        check_eq("off_bus", bus_out, 8'h00);
        check_eq("off_en", {lhs_en, rhs_en, bus_en}, 3'b000);

        // Write is not visible before the edge
        load_bus = 1; load_sel = 2'd0; bus_in = 8'h99;
        lhs_sel = 2'd0; assert_lhs = 1;
        #1;
        check_eq("no_bypass", lhs_out, 8'h11);
        tick();
        check_eq("after_edge", lhs_out, 8'h99);
        load_bus = 0; assert_lhs = 0;

        // Pair carry and borrow
        load_reg(2'd0, 8'hFF);
        load_reg(2'd1, 8'h00);
        pair_sel = 1'b0; pair_inc = 1; tick(); pair_inc = 0;
        check_eq("pair_carry", pair_out, 16'h0100);
        load_reg(2'd0, 8'h00);
        load_reg(2'd1, 8'h00);
        pair_dec = 1; tick(); pair_dec = 0;
        check_eq("pair_borrow", pair_out, 16'hFFFF);
        pair_inc = 1; pair_dec = 1; tick(); pair_inc = 0; pair_dec = 0;
        check_eq("pair_both_noop", pair_out, 16'hFFFF);

        // Load vs pair op collision
        pair_inc = 1; load_reg(2'd1, 8'h5A); pair_inc = 0;
        check_eq("same_pair_load", pair_out, 16'h5AFF);
        pair_inc = 1; load_reg(2'd2, 8'h77); pair_inc = 0;
        check_eq("diff_pair_inc", pair_out, 16'h5B00);
        chk_reg("diff_pair_r2", 2'd2, 8'h77);

        // Exchange r0 <-> r3 with ignored requests while busy
        load_reg(2'd0, 8'hAA);
        load_reg(2'd3, 8'h55);
        xchg_a = 2'd0; xchg_b = 2'd3; xchg_start = 1;
        tick();
        check_eq("x_busy1", busy, 1);
        check_eq("x_state1", xchg_state, 2'd1);
        xchg_a = 2'd1; xchg_b = 2'd2;
        load_bus = 1; load_sel = 2'd0; bus_in = 8'hEE;
        pair_sel = 1'b1; pair_inc = 1;
        tick();
        check_eq("x_busy2", busy, 1);
        check_eq("x_state2", xchg_state, 2'd2);
        tick();
        check_eq("x_busy3", busy, 1);
        check_eq("x_state3", xchg_state, 2'd3);
        tick();
        xchg_start = 0; load_bus = 0; pair_inc = 0;
        check_eq("x_done", busy, 0);
        chk_reg("x_r0", 2'd0, 8'h55);
        chk_reg("x_r3", 2'd3, 8'hAA);
        check_eq("x_pair1", pair_out, 16'hAA77);
        pair_sel = 1'b0;
        #1;
        check_eq("x_pair0", pair_out, 16'h5B55);

        // Reset during MOVE aborts
        xchg_a = 2'd1; xchg_b = 2'd2; xchg_start = 1;
        tick();
        xchg_start = 0;
        tick();
        check_eq("abort_in_move", xchg_state, 2'd2);
        reset = 1;
        tick();
        reset = 0;
        check_eq("abort_busy", busy, 0);
        chk_reg("abort_r1", 2'd1, 8'h00);
        chk_reg("abort_r2", 2'd2, 8'h00);
        check_eq("abort_pair0", pair_out, 16'h0000);

        // Exchange with itself
        load_reg(2'd2, 8'h3C);
        xchg_a = 2'd2; xchg_b = 2'd2; xchg_start = 1;
        tick();
        xchg_start = 0;
        check_eq("self_busy", busy, 1);
        tick(); tick(); tick();
        check_eq("self_done", busy, 0);
        chk_reg("self_r2", 2'd2, 8'h3C);

        // WIDTH=4, NUM_REGS=2
        s_load(1'b0, 4'hF);
        s_load(1'b1, 4'hF);
        s_pair_inc = 1; tick(); s_pair_inc = 0;
        check_eq("s_wrap", s_pair_out, 8'h00);
        s_load(1'b0, 4'h3);
        s_load(1'b1, 4'hC);
        s_xchg_a = 1'b0; s_xchg_b = 1'b1; s_xchg_start = 1;
        tick();
        s_xchg_start = 0;
        check_eq("s_busy", s_busy, 1);
        tick(); tick(); tick();
        check_eq("s_done", s_busy, 0);
        check_eq("s_xchg_pair", s_pair_out, 8'h3C);

        // WIDTH=16, NUM_REGS=8
        w_pair_sel = 2'd3; w_pair_dec = 1; tick(); w_pair_dec = 0;
        check_eq("w_borrow_wrap", w_pair_out, 32'hFFFF_FFFF);
        w_pair_inc = 1; tick(); w_pair_inc = 0;
        check_eq("w_carry_wrap", w_pair_out, 32'h0000_0000);
        w_load(3'd0, 16'h1234);
        w_load(3'd7, 16'hABCD);
        w_xchg_a = 3'd0; w_xchg_b = 3'd7; w_xchg_start = 1;
        tick();
        w_xchg_start = 0;
        tick(); tick(); tick();
        check_eq("w_done", w_busy, 0);
        check_eq("w_pair3", w_pair_out, 32'h1234_0000);
        w_bus_sel = 3'd0; w_assert_bus = 1;
        #1;
        check_eq("w_r0", w_bus_out, 16'hABCD);
        w_assert_bus = 0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
